// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM encoding
// and a constant clog2 used to size the nibble index.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Purely combinational 4-bit adder with carry in/out; the one adder shared by
// every nibble of a serial operation.
module nibble_adder
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds WIDTH-bit operands one nibble per clock, LSB first, between a
// valid/ready source and sink. Define SERIAL_SUB_EN to make 'sub' select A-B.
module nibble_serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (clog2(NIBBLES) < 1) ? 1 : clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t               state;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;     // already inverted for subtraction
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  logic [NIBBLE_W-1:0]  nib_a;
  logic [NIBBLE_W-1:0]  nib_b;
  logic [NIBBLE_W-1:0]  nib_sum;
  logic                 nib_cout;

  assign nib_a = a_r[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_r[idx*NIBBLE_W +: NIBBLE_W];

  nibble_adder u_nibble_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

`ifndef SERIAL_SUB_EN
  logic unused_sub;
  assign unused_sub = sub;
`endif

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too; they are few flops and this
      // keeps the datapath free of X after reset.
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
`ifdef SERIAL_SUB_EN
            b_r      <= sub ? ~b : b;
            carry    <= sub;
`else
            b_r      <= b;
            carry    <= 1'b0;
`endif
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
          carry <= nib_cout;
          if (idx == LAST_IDX) begin
            carry_out <= nib_cout;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench: table of 16-bit vectors, backpressure and mid-op reset
// sequences, and an exhaustive back-to-back run on a WIDTH=4 instance.
module tb_nibble_serial_adder_ctrl;

  logic clk;
  logic rst_n;

  // WIDTH=16 instance
  logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16;
  logic        cout16, busy16;
  logic [15:0] a16, b16, sum16;

  // WIDTH=4 instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0]  a4, b4, sum4;

  int n_checks;
  int n_errors;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .sub       (sub16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .sum       (sum16),
    .carry_out (cout16),
    .busy      (busy16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .sub       (1'b0),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .carry_out (cout4),
    .busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one operation and waits for out_valid. 'edges' counts posedges
  // starting with the accept edge; a timeout returns a large value.
  task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                         output logic [15:0] rs, output logic rc, output int edges,
                         output logic run_busy, output logic run_ready);
    @(negedge clk);
    a16 = ta; b16 = tb; sub16 = ts; in_valid16 = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid16 = 1'b0;
    run_busy  = busy16;
    run_ready = in_ready16;
    while (!out_valid16 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    rs = sum16;
    rc = cout16;
  endtask

  initial begin
    logic [15:0] rs;
    logic        rc, rb, rr;
    int          edges;
    int          stray;
    int          bad_ready;
    int          bad_lat;
    int          n;

    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{"add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{"add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{"add_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{"add_0f0f_00f1", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[4] = '{"add_abcd_1111", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[5] = '{"add_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1};
`ifdef SERIAL_SUB_EN
    vecs[6] = '{"sub_5_7",       16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0};
    vecs[7] = '{"sub_7_5",       16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1};
    vecs[8] = '{"sub_1234_1234", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1};
`else
    vecs[6] = '{"sub_ign_5_7",   16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0};
    vecs[7] = '{"sub_ign_7_5",   16'h0007, 16'h0005, 1'b1, 16'h000C, 1'b0};
    vecs[8] = '{"sub_ign_1234",  16'h1234, 16'h1234, 1'b1, 16'h2468, 1'b0};
`endif

    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; out_ready16 = 1'b1;
    in_valid4  = 1'b0; a4  = '0; b4  = '0; out_ready4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready",  32'(in_ready16),  32'd1);
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_busy",      32'(busy16),      32'd0);
    check("rst_sum",       32'(sum16),       32'd0);
    check("rst_carry_out", 32'(cout16),      32'd0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_op16(vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, edges, rb, rr);
      check({vecs[i].name, "_sum"},     32'(rs),    32'(vecs[i].sum));
      check({vecs[i].name, "_cout"},    32'(rc),    32'(vecs[i].cout));
      check({vecs[i].name, "_latency"}, 32'(edges), 32'd5);
      if (i == 0) begin
        check("run_busy",     32'(rb), 32'd1);
        check("run_in_ready", 32'(rr), 32'd0);
      end
    end

    // Backpressure: hold out_ready low for 3 cycles in DONE
    @(negedge clk);
    out_ready16 = 1'b0;
    do_op16(16'h1234, 16'h4321, 1'b0, rs, rc, edges, rb, rr);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", k), 32'(out_valid16), 32'd1);
      check($sformatf("bp%0d_sum", k),       32'(sum16),       32'h5555);
      check($sformatf("bp%0d_cout", k),      32'(cout16),      32'd0);
      check($sformatf("bp%0d_in_ready", k),  32'(in_ready16),  32'd0);
    end
    out_ready16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", 32'(out_valid16), 32'd0);
    check("bp_release_in_ready",  32'(in_ready16),  32'd1);
    check("bp_release_busy",      32'(busy16),      32'd0);

    // Reset during the second RUN cycle
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h4321; sub16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready",  32'(in_ready16),  32'd1);
    check("midrst_out_valid", 32'(out_valid16), 32'd0);
    check("midrst_sum",       32'(sum16),       32'd0);
    check("midrst_busy",      32'(busy16),      32'd0);
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid16) stray++;
    end
    check("midrst_no_stale_result", 32'(stray), 32'd0);

    // Exhaustive WIDTH=4, back-to-back with in_valid held high throughout
    bad_ready = 0;
    bad_lat   = 0;
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd0; in_valid4 = 1'b1;
    for (int p = 0; p < 256; p++) begin
      logic [4:0] exp;
      exp = {1'b0, 4'(p >> 4)} + {1'b0, 4'(p)};
      n = 0;
      while (!in_ready4 && n < 10) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      // Next pair is presented immediately; it must wait for IDLE.
      if (p < 255) begin
        a4 = 4'((p + 1) >> 4);
        b4 = 4'(p + 1);
      end else begin
        in_valid4 = 1'b0;
      end
      while (!out_valid4 && edges < 10) begin
        if (in_ready4) bad_ready++;
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
      if (in_ready4) bad_ready++;
      if (edges != 2) bad_lat++;
      check($sformatf("w4_%0h_plus_%0h", p >> 4, p & 15), 32'({cout4, sum4}), 32'(exp));
    end
    check("w4_no_accept_while_busy", 32'(bad_ready), 32'd0);
    check("w4_latency",              32'(bad_lat),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
